dmem_arbiter: RTL



---
 rtl/dmem_arbiter_pkg.sv | 11 +
 rtl/dmem_arbiter_if.sv | 37 +++
 rtl/dmem_rr_pick.sv | 15 +
 rtl/dmem_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared states, port ids and alignment helpers for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG = 1'b1;
    localparam int BYTE_OFF_W = 2;
    localparam logic [BYTE_OFF_W-1:0] WORD_OFF0 = 2'd0;
    function automatic logic is_aligned(input logic [BYTE_OFF_W-1:0] off);
        return off == WORD_OFF0;
    endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two requester ports plus the data-memory pins of the arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              rq0_valid, rq0_ready, rq0_we;
    logic [ADDR_W-1:0] rq0_addr;
    logic [DATA_W-1:0] rq0_wdata;
    logic              rq1_valid, rq1_ready, rq1_we;
    logic [ADDR_W-1:0] rq1_addr;
    logic [DATA_W-1:0] rq1_wdata;
    logic              rsp0_valid, rsp0_err;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_valid, rsp1_err;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    modport slave (
        input  rq0_valid, rq0_we, rq0_addr, rq0_wdata,
        input  rq1_valid, rq1_we, rq1_addr, rq1_wdata,
        input  mem_rdata,
        output rq0_ready, rq1_ready,
        output rsp0_valid, rsp0_err, rsp0_rdata,
        output rsp1_valid, rsp1_err, rsp1_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata
    );
    modport master (
        output rq0_valid, rq0_we, rq0_addr, rq0_wdata,
        output rq1_valid, rq1_we, rq1_addr, rq1_wdata,
        output mem_rdata,
        input  rq0_ready, rq1_ready,
        input  rsp0_valid, rsp0_err, rsp0_rdata,
        input  rsp1_valid, rsp1_err, rsp1_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: combinational two-way picker returning a one-hot grant
module dmem_rr_pick
    import dmem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] gnt
);
    always_comb begin
        gnt[PORT_CORE] = valid[PORT_CORE] && (!valid[PORT_DBG] || FIXED_PRIO || ptr == PORT_CORE);
        gnt[PORT_DBG] = valid[PORT_DBG] && !gnt[PORT_CORE];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port word memory between core and debug requesters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic            clk,
    input logic            rst,
    dmem_arbiter_if.slave  bus
);
    state_t state_q, state_d;
    logic ptr_q, ptr_d, port_q, port_d, we_q, we_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d, acc_addr;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, acc_wdata;
    logic [1:0] gnt;
    logic idle, sel, acc_we, rsp_v, rsp0_v, rsp1_v;

    dmem_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .valid({bus.rq1_valid, bus.rq0_valid}),
        .ptr(ptr_q),
        .gnt(gnt)
    );

    assign idle = state_q == IDLE;
    assign sel = gnt[PORT_DBG];
    assign acc_we = sel ? bus.rq1_we : bus.rq0_we;
    assign acc_addr = sel ? bus.rq1_addr : bus.rq0_addr;
    assign acc_wdata = sel ? bus.rq1_wdata : bus.rq0_wdata;

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        port_d = port_q;
        we_d = we_q;
        err_d = err_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        rdata_d = (state_q == ACCESS && !we_q) ? bus.mem_rdata : '0;
        case (state_q)
            IDLE: if (|gnt) begin
                port_d = sel;
                we_d = acc_we;
                ptr_d = !sel;
                err_d = !is_aligned(acc_addr[BYTE_OFF_W-1:0]);
                state_d = err_d ? RESP : ACCESS;
                // memory-side address/data only move for accesses that will strobe
                addr_d = err_d ? addr_q : acc_addr;
                wdata_d = err_d ? wdata_q : acc_wdata;
            end
            ACCESS: state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= PORT_CORE;
            port_q <= PORT_CORE;
            we_q <= 1'b0;
            err_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            port_q <= port_d;
            we_q <= we_d;
            err_q <= err_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign rsp_v = state_q == RESP;
    assign rsp0_v = rsp_v && port_q == PORT_CORE;
    assign rsp1_v = rsp_v && port_q == PORT_DBG;
    assign bus.rq0_ready = idle && gnt[PORT_CORE];
    assign bus.rq1_ready = idle && gnt[PORT_DBG];
    assign bus.rsp0_valid = rsp0_v;
    assign bus.rsp1_valid = rsp1_v;
    assign bus.rsp0_err = rsp0_v && err_q;
    assign bus.rsp1_err = rsp1_v && err_q;
    assign bus.rsp0_rdata = rsp0_v ? rdata_q : '0;
    assign bus.rsp1_rdata = rsp1_v ? rdata_q : '0;
    assign bus.mem_read = state_q == ACCESS && !we_q;
    assign bus.mem_write = state_q == ACCESS && we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule
